// File: rtl/cpld_bank_latch_sync.sv
// -----------------------------------------------------------------------------
// cpld_bank_latch_sync
//
// Synchronous replacement for the 512K RAM expansion bank-select latch. The
// asynchronous Z80 I/O-write strobes, address bit 15, data bus and CPC bus
// reset are brought into the clk domain through equal-depth synchronizer
// chains. The write strobe is glitch-filtered, and a gate-array RAM
// configuration write (adr15=0, data[7:6]=11) loads the 6-bit bank value.
//
// Parameters:
//   SYNC_STAGES  flops per synchronizer chain (2..3)
//   FILTER       consecutive qualified samples needed before capture (1..15)
//
// Ports:
//   clk           system clock, rising-edge active
//   reset         synchronous active-high reset
//   cpc_reset_b   CPC bus reset, asynchronous, active low
//   iorq_b        Z80 I/O request, active low, asynchronous
//   wr_b          Z80 write strobe, active low, asynchronous
//   adr15         Z80 address bit 15, asynchronous
//   data          Z80 data bus, asynchronous
//   ramblock      current bank configuration {ccc,bbb}
//   ramblock_upd  one-cycle pulse when ramblock is loaded from a bus write
//   busy          high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module cpld_bank_latch_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER      = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpc_reset_b,
   input  logic       iorq_b,
   input  logic       wr_b,
   input  logic       adr15,
   input  logic [7:0] data,
   output logic [5:0] ramblock,
   output logic       ramblock_upd,
   output logic       busy
);

   localparam logic [3:0] FILT_W = 4'(FILTER);

   typedef enum logic [1:0] {
      S_IDLE,
      S_QUAL,
      S_HOLD
   } state_t;

   // Synchronizer chains, all of identical depth so data stays aligned with
   // the strobes.
   logic [SYNC_STAGES-1:0] iorq_sq;
   logic [SYNC_STAGES-1:0] wr_sq;
   logic [SYNC_STAGES-1:0] adr15_sq;
   logic [SYNC_STAGES-1:0] cpcrst_sq;
   logic [7:0]             data_sq [SYNC_STAGES];

   logic       iorq_s;
   logic       wr_s;
   logic       adr15_s;
   logic       cpcrst_s;
   logic [7:0] data_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         iorq_sq   <= '1;
         wr_sq     <= '1;
         adr15_sq  <= '1;
         cpcrst_sq <= '1;
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            data_sq[i] <= '0;
         end
      end else begin
         iorq_sq   <= {iorq_sq[SYNC_STAGES-2:0], iorq_b};
         wr_sq     <= {wr_sq[SYNC_STAGES-2:0], wr_b};
         adr15_sq  <= {adr15_sq[SYNC_STAGES-2:0], adr15};
         cpcrst_sq <= {cpcrst_sq[SYNC_STAGES-2:0], cpc_reset_b};
         data_sq[0] <= data;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            data_sq[i] <= data_sq[i-1];
         end
      end
   end

   assign iorq_s   = iorq_sq[SYNC_STAGES-1];
   assign wr_s     = wr_sq[SYNC_STAGES-1];
   assign adr15_s  = adr15_sq[SYNC_STAGES-1];
   assign cpcrst_s = cpcrst_sq[SYNC_STAGES-1];
   assign data_s   = data_sq[SYNC_STAGES-1];

   // Filter FSM and registered outputs
   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [5:0] ramblock_q;
   logic       upd_q;
   logic       busy_q;
   logic       rst_q;      // previous cycle was held in reset
   logic       qual;
   logic       capture;
   logic       ram_wr;

   assign qual   = ~iorq_s & ~wr_s & ~adr15_s;
   assign ram_wr = capture & (data_s[7:6] == 2'b11);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      if (rst_q) begin
         // Coming out of reset with the strobe still low means we are in the
         // middle of an aborted write: park in HOLD until iorq_b goes high.
         state_d = iorq_s ? S_IDLE : S_HOLD;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (qual) begin
                  cnt_d = 4'd1;
                  if (FILTER == 1) begin
                     capture = 1'b1;
                     state_d = S_HOLD;
                  end else begin
                     state_d = S_QUAL;
                  end
               end
            end
            S_QUAL: begin
               if (qual) begin
                  cnt_d = cnt_q + 4'd1;
                  if ((cnt_q + 4'd1) == FILT_W) begin
                     capture = 1'b1;
                     state_d = S_HOLD;
                  end
               end else begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end
            end
            S_HOLD: begin
               if (iorq_s) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !cpcrst_s) begin
         // Either reset source beats a capture on the same edge.
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ramblock_q <= '0;
         upd_q      <= 1'b0;
         busy_q     <= 1'b0;
         rst_q      <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != S_IDLE);
         upd_q   <= ram_wr;
         rst_q   <= 1'b0;
         if (ram_wr) begin
            ramblock_q <= data_s[5:0];
         end
      end
   end

   assign ramblock     = ramblock_q;
   assign ramblock_upd = upd_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_cpld_bank_latch_sync.sv
module tb_cpld_bank_latch_sync;

   logic       clk = 1'b0;
   logic       reset;
   logic       cpc_reset_b;
   logic       iorq_b;
   logic       wr_b;
   logic       adr15;
   logic [7:0] data;
   logic [5:0] ramblock;
   logic       ramblock_upd;
   logic       busy;

   cpld_bank_latch_sync #(
      .SYNC_STAGES(2),
      .FILTER     (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cpc_reset_b (cpc_reset_b),
      .iorq_b      (iorq_b),
      .wr_b        (wr_b),
      .adr15       (adr15),
      .data        (data),
      .ramblock    (ramblock),
      .ramblock_upd(ramblock_upd),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [5:0] val;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;
   int   pushes = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic bus(input logic io, input logic w, input logic a, input logic [7:0] d);
      iorq_b = io;
      wr_b   = w;
      adr15  = a;
      data   = d;
   endtask

   // Raw inputs driven just before edge n = cyc+1; update expected at n+3.
   task automatic expect_upd(input logic [5:0] v);
      exp_t e;
      e.val = v;
      e.cyc = cyc + 4;
      q.push_back(e);
      pushes++;
   endtask

   // Monitor: pops and compares on every update pulse.
   logic prev_upd = 1'b0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (ramblock_upd) begin
            pulses++;
            chk("upd_width", {31'd0, prev_upd}, 32'd0);
            if (q.size() == 0) begin
               chk("unexpected_upd", {26'd0, ramblock}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("upd_value", {26'd0, ramblock}, {26'd0, e.val});
               chk("upd_cycle", cyc, e.cyc);
            end
         end
         prev_upd = ramblock_upd;
      end
   end

   initial begin
      int k;
      reset       = 1'b1;
      cpc_reset_b = 1'b1;
      bus(1, 1, 1, 8'h00);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_ramblock", {26'd0, ramblock}, 32'd0);
      chk("rst_upd", {31'd0, ramblock_upd}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);

      // Default RAM write
      k = cyc;
      expect_upd(6'h16);
      bus(0, 0, 0, 8'hD6);
      repeat (2) @(negedge clk);
      chk("busy_pre", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("busy_rise", {31'd0, busy}, 32'd1);
      repeat (3) @(negedge clk);
      bus(1, 1, 1, 8'h00);
      repeat (2) @(negedge clk);
      chk("busy_hold", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("busy_fall", {31'd0, busy}, 32'd0);
      chk("wr1_ramblock", {26'd0, ramblock}, 32'h16);
      chk("wr1_drained", q.size(), 32'd0);
      repeat (2) @(negedge clk);

      // Non-RAM gate-array write
      bus(0, 0, 0, 8'h8C);
      repeat (3) @(negedge clk);
      chk("nr_busy_rise", {31'd0, busy}, 32'd1);
      repeat (3) @(negedge clk);
      bus(1, 1, 1, 8'h00);
      repeat (3) @(negedge clk);
      chk("nr_busy_fall", {31'd0, busy}, 32'd0);
      chk("nr_ramblock", {26'd0, ramblock}, 32'h16);
      repeat (2) @(negedge clk);

      // One-clock glitch, then adr15=1 write
      bus(0, 0, 0, 8'hC5);
      @(negedge clk);
      bus(1, 1, 1, 8'h00);
      repeat (6) @(negedge clk);
      chk("glitch_ramblock", {26'd0, ramblock}, 32'h16);
      chk("glitch_busy", {31'd0, busy}, 32'd0);
      bus(0, 0, 1, 8'hFF);
      repeat (6) @(negedge clk);
      bus(1, 1, 1, 8'h00);
      repeat (4) @(negedge clk);
      chk("a15_ramblock", {26'd0, ramblock}, 32'h16);

      // Long strobe, short release, second write
      expect_upd(6'h15);
      bus(0, 0, 0, 8'hD5);
      repeat (20) @(negedge clk);
      bus(1, 1, 1, 8'h00);
      @(negedge clk);
      expect_upd(6'h02);
      bus(0, 0, 0, 8'hC2);
      repeat (6) @(negedge clk);
      bus(1, 1, 1, 8'h00);
      repeat (4) @(negedge clk);
      chk("b2b_ramblock", {26'd0, ramblock}, 32'h02);
      chk("b2b_pulses", pulses, 32'd3);

      // Load 3F, then CPC reset overlapping a capture edge
      expect_upd(6'h3F);
      bus(0, 0, 0, 8'hFF);
      repeat (6) @(negedge clk);
      bus(1, 1, 1, 8'h00);
      repeat (4) @(negedge clk);
      chk("pre_cpc_ramblock", {26'd0, ramblock}, 32'h3F);
      k = cyc;
      bus(0, 0, 0, 8'hC7);
      @(negedge clk);
      cpc_reset_b = 1'b0;
      repeat (2) @(negedge clk);
      chk("cpc_not_yet", {26'd0, ramblock}, 32'h3F);
      @(negedge clk);
      chk("cpc_clear", {26'd0, ramblock}, 32'h00);
      chk("cpc_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      cpc_reset_b = 1'b1;
      repeat (3) @(negedge clk);
      chk("cpc_exit_hold", {31'd0, busy}, 32'd1);
      repeat (6) @(negedge clk);
      chk("cpc_no_capture", {26'd0, ramblock}, 32'h00);
      bus(1, 1, 1, 8'h00);
      repeat (4) @(negedge clk);
      chk("cpc_idle", {31'd0, busy}, 32'd0);

      // Recovery write
      expect_upd(6'h09);
      bus(0, 0, 0, 8'hC9);
      repeat (6) @(negedge clk);
      bus(1, 1, 1, 8'h00);
      repeat (4) @(negedge clk);
      chk("rec_ramblock", {26'd0, ramblock}, 32'h09);
      chk("final_drained", q.size(), 32'd0);
      chk("final_pulses", pulses, pushes);
      if (k < 0) $display("cycle %0d", k);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
